// File: rtl/minv_mdiv_sched.sv
// Round-robin scheduler for two requesters sharing the MINV/MDIV engine.
// It streams the operands in, starts the engine, waits for it under a watchdog, then streams the result back.
module minv_mdiv_sched #(
    parameter int WORDS   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          rq_req,
    input  logic [1:0]          rq_mdiv,
    input  logic [1:0]          rq_wvalid,
    input  logic [2*32-1:0]     rq_wdata,
    output logic [1:0]          rq_wready,
    output logic [1:0]          gnt,
    output logic                rsp_valid,
    output logic [31:0]         rsp_data,
    output logic                rsp_last,
    output logic                rsp_err,
    input  logic                rsp_ready,
    output logic [31:0]         ld_data,
    output logic [1:0]          ld_sel,
    output logic                ld_we,
    output logic                op_mdiv,
    output logic                op_start,
    input  logic                op_rdy,
    input  logic                op_flag,
    input  logic [31:0]         res_data,
    output logic                res_shift
);

    localparam int CW = $clog2(4 * WORDS);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            rr_q, rr_d;
    logic            op_mdiv_q, op_mdiv_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic            rsp_err_q, rsp_err_d;
    logic            tmo_q, tmo_d;

    logic [31:0]     wdata_w [2];
    logic            gidx;
    logic            pick;
    logic            beat;
    logic [CW-1:0]   last_load;
    logic [WW-1:0]   wdog_inc;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign wdata_w[gi] = rq_wdata[gi*32 +: 32];
    end

    assign gidx      = gnt_q[1];
    // With both requesting the pointer decides; otherwise whoever is asking wins.
    assign pick      = (&rq_req) ? rr_q : rq_req[1];
    assign beat      = rq_wvalid[gidx];
    assign last_load = op_mdiv_q ? CW'(4 * WORDS - 1) : CW'(3 * WORDS - 1);
    assign wdog_inc  = wdog_q + WW'(1);
    assign gnt       = gnt_q;
    assign op_mdiv   = op_mdiv_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            rr_q      <= 1'b0;
            op_mdiv_q <= 1'b0;
            cnt_q     <= '0;
            wdog_q    <= '0;
            rsp_err_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            op_mdiv_q <= op_mdiv_d;
            cnt_q     <= cnt_d;
            wdog_q    <= wdog_d;
            rsp_err_q <= rsp_err_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        op_mdiv_d = op_mdiv_q;
        cnt_d     = cnt_q;
        wdog_d    = wdog_q;
        rsp_err_d = rsp_err_q;
        tmo_d     = tmo_q;
        rq_wready = '0;
        ld_we     = 1'b0;
        ld_sel    = '0;
        ld_data   = '0;
        op_start  = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;
        res_shift = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|rq_req) begin
                    gnt_d     = pick ? 2'b10 : 2'b01;
                    rr_d      = ~pick;
                    op_mdiv_d = rq_mdiv[pick];
                    cnt_d     = '0;
                    rsp_err_d = 1'b0;
                    tmo_d     = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                rq_wready = gnt_q;
                if (beat) begin
                    ld_we   = 1'b1;
                    ld_data = wdata_w[gidx];
                    ld_sel  = 2'(cnt_q / CW'(WORDS));
                    if (cnt_q == last_load) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_START: begin
                op_start = 1'b1;
                wdog_d   = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_inc;
                // The first WAIT cycle may still see the previous operation's ready flag.
                if (wdog_q != '0 && op_rdy) begin
                    rsp_err_d = op_flag;
                    state_d   = S_UNLOAD;
                end else if (wdog_inc == WW'(TIMEOUT)) begin
                    rsp_err_d = 1'b1;
                    tmo_d     = 1'b1;
                    state_d   = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                rsp_valid = 1'b1;
                rsp_data  = tmo_q ? 32'h0 : res_data;
                rsp_last  = (cnt_q == CW'(WORDS - 1));
                rsp_err   = rsp_err_q;
                if (rsp_ready) begin
                    res_shift = ~tmo_q;
                    if (rsp_last) begin
                        cnt_d   = '0;
                        gnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_minv_mdiv_sched.sv
// Scoreboard bench for minv_mdiv_sched with a behavioural engine model (XOR-combining result, programmable latency).
module tb_minv_mdiv_sched;
    localparam int WORDS   = 8;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  rq_req, rq_mdiv, rq_wvalid, rq_wready, gnt;
    logic [63:0] rq_wdata;
    logic        rsp_valid, rsp_last, rsp_err, rsp_ready;
    logic [31:0] rsp_data, ld_data, res_data;
    logic [1:0]  ld_sel;
    logic        ld_we, op_mdiv, op_start, op_rdy, op_flag, res_shift;

    minv_mdiv_sched #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rq_req(rq_req), .rq_mdiv(rq_mdiv), .rq_wvalid(rq_wvalid), .rq_wdata(rq_wdata),
        .rq_wready(rq_wready), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .ld_data(ld_data), .ld_sel(ld_sel), .ld_we(ld_we),
        .op_mdiv(op_mdiv), .op_start(op_start), .op_rdy(op_rdy), .op_flag(op_flag),
        .res_data(res_data), .res_shift(res_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboards: {sel,data} per load beat, {last,err,data} per response beat
    logic [33:0] ld_q[$];
    logic [33:0] rsp_q[$];

    logic [31:0] mem [4][WORDS];
    int          widx [4];
    logic [31:0] res [WORDS];
    int          start_cyc = 0, eng_lat = 10, last_ld_cyc = 0, exp_wait = 0;
    int          n_start = 0, n_shift = 0;
    bit          eng_flag, eng_never, eng_stale, eng_run, exp_mdiv;
    bit          prev_stall, prev_valid;
    logic [31:0] prev_data;

    // Engine model + monitor: sample at negedge, update engine inputs just after posedge.
    initial begin : engine
        logic       s_we, s_start, s_shift;
        logic [1:0] s_sel;
        logic [31:0] s_data, t;
        logic [33:0] e;
        op_rdy = 0; op_flag = 0; res_data = 0;
        eng_run = 0; prev_stall = 0; prev_valid = 0; prev_data = 0;
        for (int k = 0; k < 4; k++) widx[k] = 0;
        for (int i = 0; i < WORDS; i++) res[i] = 0;
        forever begin
            @(negedge clk);
            s_we = ld_we; s_sel = ld_sel; s_data = ld_data; s_start = op_start; s_shift = res_shift;
            if (rst) begin
                if (ld_we) begin
                    if (ld_q.size() == 0) chk("ld_extra", 64'(1), 64'(0));
                    else begin
                        e = ld_q.pop_front();
                        chk("ld_sel", 64'(ld_sel), 64'(e[33:32]));
                        chk("ld_data", 64'(ld_data), 64'(e[31:0]));
                    end
                    chk("wready_other", 64'(rq_wready & ~gnt), 64'(0));
                    last_ld_cyc = cyc;
                end
                if (op_start) begin
                    n_start++;
                    chk("start_lat", 64'(cyc), 64'(last_ld_cyc + 1));
                    chk("op_mdiv", 64'(op_mdiv), 64'(exp_mdiv));
                end
                if (res_shift) begin
                    n_shift++;
                    chk("shift_gate", 64'({rsp_valid, rsp_ready}), 64'(2'b11));
                end
                if (rsp_valid) begin
                    if (!prev_valid) chk("wait_len", 64'(cyc - start_cyc), 64'(exp_wait));
                    if (prev_stall) chk("stall_data", 64'(rsp_data), 64'(prev_data));
                    if (rsp_ready) begin
                        if (rsp_q.size() == 0) chk("rsp_extra", 64'(1), 64'(0));
                        else begin
                            e = rsp_q.pop_front();
                            chk("rsp_data", 64'(rsp_data), 64'(e[31:0]));
                            chk("rsp_flags", 64'({rsp_last, rsp_err}), 64'(e[33:32]));
                        end
                    end
                    prev_stall = !rsp_ready;
                    prev_data  = rsp_data;
                end else begin
                    prev_stall = 0;
                end
                prev_valid = rsp_valid;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                op_rdy = 0; eng_run = 0; prev_valid = 0; prev_stall = 0;
                for (int k = 0; k < 4; k++) widx[k] = 0;
                for (int i = 0; i < WORDS; i++) res[i] = 0;
            end else begin
                if (s_we && widx[s_sel] < WORDS) begin
                    mem[s_sel][widx[s_sel]] = s_data;
                    widx[s_sel]++;
                end
                if (s_shift) begin
                    t = res[0];
                    for (int i = 0; i < WORDS - 1; i++) res[i] = res[i+1];
                    res[WORDS-1] = t;
                end
                if (s_start) begin
                    for (int i = 0; i < WORDS; i++) begin
                        res[i] = mem[0][i] ^ mem[1][i] ^ mem[2][i] ^ (widx[3] > i ? mem[3][i] : 32'h0)
                                 ^ (32'(i) * 32'h0101_0101);
                    end
                    for (int k = 0; k < 4; k++) widx[k] = 0;
                    start_cyc = cyc;
                    eng_run   = 1;
                    op_rdy    = eng_stale;
                end else if (eng_run) begin
                    if (eng_stale && cyc - start_cyc == 1) op_rdy = 0;
                    if (!eng_never && cyc - start_cyc == eng_lat) begin
                        op_rdy  = 1;
                        op_flag = eng_flag;
                        eng_run = 0;
                    end
                end
            end
            res_data = res[0];
        end
    end

    task automatic do_op(input int r, input bit mdiv, input int lat, input bit flag, input bit never,
                         input bit stale, input bit toggle, input bit keep_req, input bit abort);
        logic [31:0] w [4*WORDS];
        logic [31:0] ex;
        int n, idx, budget;
        bit beat, done;
        n = mdiv ? 4*WORDS : 3*WORDS;
        eng_lat = lat; eng_flag = flag; eng_never = never; eng_stale = stale;
        exp_mdiv = mdiv;
        exp_wait = never ? TIMEOUT : lat + 1;
        for (int i = 0; i < n; i++) begin
            w[i] = $urandom;
            ld_q.push_back({2'(i / WORDS), w[i]});
        end
        if (!abort) begin
            for (int i = 0; i < WORDS; i++) begin
                ex = w[i] ^ w[WORDS+i] ^ w[2*WORDS+i] ^ (mdiv ? w[3*WORDS+i] : 32'h0) ^ (32'(i) * 32'h0101_0101);
                rsp_q.push_back({(i == WORDS-1), (never | flag), (never ? 32'h0 : ex)});
            end
        end
        n_start = 0; n_shift = 0;
        rq_mdiv[r] = mdiv;
        rq_req[r]  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (gnt != 2'b00) break;
            @(posedge clk); #1;
        end
        chk("gnt", 64'(gnt), 64'(2'b01 << r));
        // The other requester offers junk words that must be ignored.
        rq_wvalid[1-r] = 1'b1;
        rq_wdata[(1-r)*32 +: 32] = 32'hDEAD_BEEF;
        rq_wvalid[r] = 1'b1;
        rq_wdata[r*32 +: 32] = w[0];
        idx = 0; budget = 200;
        while (idx < n && budget > 0) begin
            @(negedge clk);
            beat = rq_wready[r];
            @(posedge clk); #1;
            if (beat) begin
                idx++;
                if (idx < n) rq_wdata[r*32 +: 32] = w[idx];
            end
            budget--;
        end
        chk("load_beats", 64'(idx), 64'(n));
        rq_wvalid = 2'b00;
        if (abort) begin
            repeat (4) @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            chk("abort_out", 64'({gnt, rq_wready, rsp_valid, rsp_data, rsp_last, rsp_err, ld_we, ld_sel,
                                  op_mdiv, op_start, res_shift}), 64'(0));
            rq_req = 2'b00;
            rsp_q.delete();
            ld_q.delete();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            $display("op r=%0d mdiv=%0d aborted by reset", r, mdiv);
            return;
        end
        rsp_ready = 1'b1;
        done = 0; budget = 200;
        while (!done && budget > 0) begin
            @(negedge clk);
            done = rsp_valid & rsp_ready & rsp_last;
            @(posedge clk); #1;
            if (!done && toggle) rsp_ready = ~rsp_ready;
            budget--;
        end
        chk("unload_done", 64'(done), 64'(1));
        if (!keep_req) rq_req[r] = 1'b0;
        rsp_ready = 1'b0;
        chk("gnt_clear", 64'({gnt, rsp_valid}), 64'(0));
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        chk("ld_q_empty", 64'(ld_q.size()), 64'(0));
        chk("n_start", 64'(n_start), 64'(1));
        chk("n_shift", 64'(n_shift), 64'(never ? 0 : WORDS));
        $display("op r=%0d mdiv=%0d lat=%0d flag=%0d timeout=%0d stale=%0d toggle=%0d done",
                 r, mdiv, lat, flag, never, stale, toggle);
    endtask

    initial begin
        rst = 1'b0; rq_req = 0; rq_mdiv = 0; rq_wvalid = 0; rq_wdata = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 64'({gnt, rq_wready, rsp_valid, rsp_data, rsp_last, rsp_err, ld_we, ld_sel,
                              op_mdiv, op_start, res_shift}), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        // both requesting: rq0 first, then rq1 immediately after
        rq_mdiv = 2'b10;
        rq_req  = 2'b11;
        do_op(0, 0, 10, 0, 0, 0, 0, 1, 0);
        do_op(1, 1, 10, 0, 0, 1, 0, 0, 0);
        rq_req = 2'b00;
        do_op(0, 0, 10, 0, 1, 0, 0, 0, 0);
        do_op(1, 0, 5, 1, 0, 0, 1, 0, 0);
        do_op(0, 1, 10, 0, 0, 0, 0, 0, 1);
        do_op(1, 1, 3, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            do_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(2, 12)),
                  1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)), 0, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "simulation time limit");
    end
endmodule
